// File: rtl/vgachargen_pkg.sv
// vgachargen_pkg: shared geometry, register map and APB state type for the VGA char-map APB slave.
package vgachargen_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CHAR_ADDR_W = $clog2(COLS * ROWS);
  localparam int CTRL_OFF = 'h3000;
  localparam int STATUS_OFF = 'h3004;
  localparam logic [7:0] FILL_RESET = 8'h20;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
endpackage

// File: rtl/vgachargen_clear_engine.sv
// vgachargen_clear_engine: sweeps every map cell once with the fill character after a start pulse.
// Ports: clk_i/rst_ni (async active-low), start_i (ignored by caller while busy), fill_i fill character,
//        busy_o sweep running, addr_o/char_o/wen_o one map write per busy cycle.
module vgachargen_clear_engine
  import vgachargen_pkg::*;
#(
  parameter int CELLS = COLS * ROWS,
  parameter int AW = $clog2(CELLS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [7:0]    fill_i,
  output logic          busy_o,
  output logic [AW-1:0] addr_o,
  output logic [7:0]    char_o,
  output logic          wen_o
);
  logic busy_q, busy_d, more;
  logic [AW-1:0] cnt_q, cnt_d;
  always_comb begin
    more = busy_q && cnt_q != AW'(CELLS - 1);
    busy_d = start_i || more;
    cnt_d = more ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  assign busy_o = busy_q;
  assign wen_o = busy_q;
  assign addr_o = cnt_q;
  assign char_o = busy_q ? fill_i : '0;
endmodule

// File: rtl/apb_vgachargen_slave.sv
// apb_vgachargen_slave: APB3 slave turning bus writes into char-map write strobes, with a hardware clear engine.
// Ports: clk_i/rst_ni (async active-low); APB3 psel_i/penable_i/pwrite_i/paddr_i/pwdata_i -> prdata_o/pready_o/pslverr_o;
//        char_o/addr_o/wen_o char-map write port; busy_o clear engine running.
// Define VGACHARGEN_PSLVERR_EN to flag bad accesses on pslverr_o; otherwise they are silently dropped.
module apb_vgachargen_slave #(
  parameter int COLS = vgachargen_pkg::COLS,
  parameter int ROWS = vgachargen_pkg::ROWS,
  parameter int ADDR_W = 14
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [ADDR_W-1:0]            paddr_i,
  input  logic [31:0]                  pwdata_i,
  output logic [31:0]                  prdata_o,
  output logic                         pready_o,
  output logic                         pslverr_o,
  output logic [7:0]                   char_o,
  output logic [$clog2(COLS*ROWS)-1:0] addr_o,
  output logic                         wen_o,
  output logic                         busy_o
);
  import vgachargen_pkg::*;
  localparam int CELLS = COLS * ROWS;
  localparam int CW = $clog2(CELLS);
  localparam int IW = ADDR_W - 2;
  apb_state_e state_q, state_d;
  logic [7:0] fill_q, fill_d, char_q, char_d, eng_char;
  logic [CW-1:0] waddr_q, waddr_d, eng_addr;
  logic wen_q, wen_d, eng_wen, busy, start, access, char_hit, ctrl_hit, stat_hit, char_wr, ctrl_wr;
  logic [IW-1:0] idx;
  logic unused_bits;
  assign unused_bits = ^{pwdata_i[31:16], paddr_i[1:0]};
  // state_q != IDLE marks that the previous cycle was a setup (or stalled access) of the same transfer,
  // so a transfer completes exactly once even while psel/penable linger after pready.
  always_comb begin
    idx = paddr_i[ADDR_W-1:2];
    char_hit = idx < IW'(CELLS);
    ctrl_hit = idx == IW'(CTRL_OFF >> 2);
    stat_hit = idx == IW'(STATUS_OFF >> 2);
    access = psel_i && penable_i && state_q != IDLE;
    pready_o = access && !(char_hit && pwrite_i && busy);
    char_wr = pready_o && pwrite_i && char_hit;
    ctrl_wr = pready_o && pwrite_i && ctrl_hit && !busy;
    start = ctrl_wr && pwdata_i[0];
    prdata_o = (!pready_o || pwrite_i) ? '0 : ctrl_hit ? {16'h0, fill_q, 8'h0} : stat_hit ? {31'h0, busy} : '0;
    state_d = (psel_i && !penable_i) ? SETUP : (access && !pready_o) ? ACCESS : IDLE;
    fill_d = ctrl_wr ? pwdata_i[15:8] : fill_q;
    wen_d = char_wr;
    char_d = char_wr ? pwdata_i[7:0] : '0;
    waddr_d = char_wr ? idx[CW-1:0] : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      fill_q <= FILL_RESET;
      wen_q <= 1'b0;
      char_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      wen_q <= wen_d;
      char_q <= char_d;
      waddr_q <= waddr_d;
    end
`ifdef VGACHARGEN_PSLVERR_EN
  assign pslverr_o = pready_o && (char_hit ? !pwrite_i : stat_hit ? pwrite_i : !ctrl_hit);
`else
  assign pslverr_o = 1'b0;
`endif
  vgachargen_clear_engine #(.CELLS(CELLS), .AW(CW)) u_clear (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(start),
    .fill_i (fill_q),
    .busy_o (busy),
    .addr_o (eng_addr),
    .char_o (eng_char),
    .wen_o  (eng_wen)
  );
  // CHAR transfers stall while busy, so the two strobe sources never overlap.
  assign busy_o = busy;
  assign wen_o = eng_wen || wen_q;
  assign char_o = busy ? eng_char : char_q;
  assign addr_o = busy ? eng_addr : waddr_q;
endmodule
